// File: rtl/pc_stack_if.sv
// pc_stack_if: bundle between the instruction decoder/core and the PC stack controller.
//   Core -> controller: call_req, ret_req, retfie_req, int_req, gie_wr, gie_din,
//                       clr_flags, pc_cur, call_tgt, stk_top
//   Controller -> core: stk_ctl, stk_din, pc_load, pc_next, busy, int_ack,
//                       gie, depth, ovf, unf
// master = core/bench side, slave = pc_stack_ctrl.
interface pc_stack_if;
  logic        call_req;
  logic        ret_req;
  logic        retfie_req;
  logic        int_req;
  logic        gie_wr;
  logic        gie_din;
  logic        clr_flags;
  logic [10:0] pc_cur;
  logic [10:0] call_tgt;
  logic [10:0] stk_top;

  logic [1:0]  stk_ctl;
  logic [10:0] stk_din;
  logic        pc_load;
  logic [10:0] pc_next;
  logic        busy;
  logic        int_ack;
  logic        gie;
  logic [2:0]  depth;
  logic        ovf;
  logic        unf;

  modport master (
    output call_req, ret_req, retfie_req, int_req, gie_wr, gie_din, clr_flags,
           pc_cur, call_tgt, stk_top,
    input  stk_ctl, stk_din, pc_load, pc_next, busy, int_ack, gie, depth, ovf, unf
  );

  modport slave (
    input  call_req, ret_req, retfie_req, int_req, gie_wr, gie_din, clr_flags,
           pc_cur, call_tgt, stk_top,
    output stk_ctl, stk_din, pc_load, pc_next, busy, int_ack, gie, depth, ovf, unf
  );
endinterface

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: sequences CALL / RETURN / RETFIE / interrupt entry against an
// external return-address stack and tracks stack occupancy and the global
// interrupt enable.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pc_stack_if.slave (requests and stack top in; stack control, PC load,
//          busy, int_ack, gie, depth, ovf, unf out; every output is a flop)
// Stack control codes: 00 no-op, 01 push, 10 pop.
module pc_stack_ctrl #(
  parameter logic [10:0] INT_VEC   = 11'h004,
  parameter int unsigned STK_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  pc_stack_if.slave  bus
);

  localparam logic [1:0] STK_NOP = 2'b00;
  localparam logic [1:0] STK_PSH = 2'b01;
  localparam logic [1:0] STK_POP = 2'b10;

  localparam logic [2:0] DepthMax = 3'(STK_DEPTH);

  typedef enum logic {StIdle, StSettle} state_e;

  state_e      state_q, state_d;
  logic [1:0]  stk_ctl_q, stk_ctl_d;
  logic [10:0] stk_din_q, stk_din_d;
  logic        pc_load_q, pc_load_d;
  logic [10:0] pc_next_q, pc_next_d;
  logic        int_ack_q, int_ack_d;
  logic        gie_q, gie_d;
  logic [2:0]  depth_q, depth_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        take_int;
  logic        do_push;
  logic        do_pop;

  assign take_int = bus.int_req & gie_q;

  always_comb begin
    state_d   = StIdle;
    stk_ctl_d = STK_NOP;
    stk_din_d = stk_din_q;
    pc_load_d = 1'b0;
    pc_next_d = pc_next_q;
    int_ack_d = 1'b0;
    depth_d   = depth_q;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    // Software writes and flag clears apply in both states; the request
    // decode below overrides them where set/clear priority demands it.
    gie_d     = bus.gie_wr ? bus.gie_din : gie_q;
    ovf_d     = bus.clr_flags ? 1'b0 : ovf_q;
    unf_d     = bus.clr_flags ? 1'b0 : unf_q;

    unique case (state_q)
      StIdle: begin
        if (take_int) begin
          // Push the interrupted PC itself so that instruction is re-executed.
          do_push   = 1'b1;
          stk_din_d = bus.pc_cur;
          pc_next_d = INT_VEC;
          gie_d     = 1'b0;
          int_ack_d = 1'b1;
        end else if (bus.call_req) begin
          do_push   = 1'b1;
          stk_din_d = bus.pc_cur + 11'd1;
          pc_next_d = bus.call_tgt;
        end else if (bus.retfie_req) begin
          do_pop    = 1'b1;
          pc_next_d = bus.stk_top;
          gie_d     = 1'b1;
        end else if (bus.ret_req) begin
          do_pop    = 1'b1;
          pc_next_d = bus.stk_top;
        end

        if (do_push) begin
          stk_ctl_d = STK_PSH;
          pc_load_d = 1'b1;
          state_d   = StSettle;
          // A full stack still pushes (oldest entry falls off); depth saturates.
          if (depth_q == DepthMax) begin
            ovf_d = 1'b1;
          end else begin
            depth_d = depth_q + 3'd1;
          end
        end

        if (do_pop) begin
          stk_ctl_d = STK_POP;
          pc_load_d = 1'b1;
          state_d   = StSettle;
          if (depth_q == 3'd0) begin
            unf_d = 1'b1;
          end else begin
            depth_d = depth_q - 3'd1;
          end
        end
      end
      // One dead cycle so stk_top reflects the last push/pop before the next op.
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      stk_ctl_q <= STK_NOP;
      stk_din_q <= 11'd0;
      pc_load_q <= 1'b0;
      pc_next_q <= 11'd0;
      int_ack_q <= 1'b0;
      gie_q     <= 1'b0;
      depth_q   <= 3'd0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stk_ctl_q <= stk_ctl_d;
      stk_din_q <= stk_din_d;
      pc_load_q <= pc_load_d;
      pc_next_q <= pc_next_d;
      int_ack_q <= int_ack_d;
      gie_q     <= gie_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.stk_ctl = stk_ctl_q;
  assign bus.stk_din = stk_din_q;
  assign bus.pc_load = pc_load_q;
  assign bus.pc_next = pc_next_q;
  assign bus.int_ack = int_ack_q;
  assign bus.gie     = gie_q;
  assign bus.depth   = depth_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
  assign bus.busy    = (state_q == StSettle);

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// tb_pc_stack_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model of the return-address stack. The bench also
// plays the external 4-deep stack memory, reacting to the DUT's stk_ctl.
module tb_pc_stack_ctrl;

  localparam logic [10:0] IntVec   = 11'h004;
  localparam int          StkDepth = 4;
  localparam logic [1:0]  CtlNop   = 2'b00;
  localparam logic [1:0]  CtlPsh   = 2'b01;
  localparam logic [1:0]  CtlPop   = 2'b10;
  localparam logic [10:0] EmptyTop = 11'h3FF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_stack_if bus ();

  pc_stack_ctrl #(
    .INT_VEC   (IntVec),
    .STK_DEPTH (StkDepth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [10:0] ret_q[$];   // model's view of live return addresses, newest first
  logic [10:0] mem_q[$];   // environment stack memory driven by DUT stk_ctl
  bit          m_busy, m_gie, m_ovf, m_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic update_top();
    bus.stk_top = (mem_q.size() != 0) ? mem_q[0] : EmptyTop;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_gie = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    ret_q.delete();
    mem_q.delete();
    update_top();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"},   32'(bus.stk_ctl), 32'(CtlNop));
    check_eq({tag, "_din"},   32'(bus.stk_din), 0);
    check_eq({tag, "_load"},  32'(bus.pc_load), 0);
    check_eq({tag, "_next"},  32'(bus.pc_next), 0);
    check_eq({tag, "_ack"},   32'(bus.int_ack), 0);
    check_eq({tag, "_gie"},   32'(bus.gie),     0);
    check_eq({tag, "_depth"}, 32'(bus.depth),   0);
    check_eq({tag, "_ovf"},   32'(bus.ovf),     0);
    check_eq({tag, "_unf"},   32'(bus.unf),     0);
    check_eq({tag, "_busy"},  32'(bus.busy),    0);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), predict the
  // outcome, then check every output at the next falling edge.
  task automatic step(input bit c, input bit r, input bit rf, input bit ir, input bit gw,
                      input bit gd, input bit cf, input logic [10:0] pc,
                      input logic [10:0] tgt);
    logic [1:0]  e_ctl;
    logic [10:0] e_din, e_next, push_val;
    bit          e_load, e_ack, n_busy, n_gie, n_ovf, n_unf, do_push, do_pop;

    bus.call_req = c;  bus.ret_req = r;  bus.retfie_req = rf;  bus.int_req = ir;
    bus.gie_wr = gw;   bus.gie_din = gd; bus.clr_flags = cf;
    bus.pc_cur = pc;   bus.call_tgt = tgt;

    n_gie = gw ? gd : m_gie;
    n_ovf = cf ? 1'b0 : m_ovf;
    n_unf = cf ? 1'b0 : m_unf;
    e_ctl = CtlNop; e_load = 1'b0; e_ack = 1'b0; n_busy = 1'b0;
    e_din = 11'd0; e_next = 11'd0; push_val = 11'd0;
    do_push = 1'b0; do_pop = 1'b0;

    if (!m_busy) begin
      if (ir && m_gie) begin
        do_push = 1'b1; push_val = pc; e_next = IntVec; n_gie = 1'b0; e_ack = 1'b1;
      end else if (c) begin
        do_push = 1'b1; push_val = pc + 11'd1; e_next = tgt;
      end else if (rf) begin
        do_pop = 1'b1; n_gie = 1'b1;
      end else if (r) begin
        do_pop = 1'b1;
      end
    end
    if (do_push) begin
      e_ctl = CtlPsh; e_din = push_val; e_load = 1'b1; n_busy = 1'b1;
      ret_q.push_front(push_val);
      if (ret_q.size() > StkDepth) begin
        void'(ret_q.pop_back());
        n_ovf = 1'b1;
      end
    end
    if (do_pop) begin
      e_ctl = CtlPop; e_load = 1'b1; n_busy = 1'b1;
      if (ret_q.size() == 0) begin
        e_next = bus.stk_top;
        n_unf  = 1'b1;
      end else begin
        e_next = ret_q.pop_front();
      end
    end

    @(negedge clk);
    check_eq("stk_ctl", 32'(bus.stk_ctl), 32'(e_ctl));
    if (e_ctl == CtlPsh) check_eq("stk_din", 32'(bus.stk_din), 32'(e_din));
    check_eq("pc_load", 32'(bus.pc_load), 32'(e_load));
    if (e_load) check_eq("pc_next", 32'(bus.pc_next), 32'(e_next));
    check_eq("int_ack", 32'(bus.int_ack), 32'(e_ack));
    check_eq("busy",    32'(bus.busy),    32'(n_busy));
    check_eq("gie",     32'(bus.gie),     32'(n_gie));
    check_eq("depth",   32'(bus.depth),   32'(ret_q.size()));
    check_eq("ovf",     32'(bus.ovf),     32'(n_ovf));
    check_eq("unf",     32'(bus.unf),     32'(n_unf));

    m_busy = n_busy; m_gie = n_gie; m_ovf = n_ovf; m_unf = n_unf;

    // Environment stack reacts to what the DUT actually issued.
    if (bus.stk_ctl == CtlPsh) begin
      mem_q.push_front(bus.stk_din);
      if (mem_q.size() > StkDepth) void'(mem_q.pop_back());
    end else if (bus.stk_ctl == CtlPop && mem_q.size() != 0) begin
      void'(mem_q.pop_front());
    end
    update_top();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 11'h000, 11'h000);
  endtask

  task automatic reset_now(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    check_reset_outputs({tag, "_hold"});
    rst = 1'b0;
  endtask

  initial begin
    bus.call_req = 0; bus.ret_req = 0; bus.retfie_req = 0; bus.int_req = 0;
    bus.gie_wr = 0; bus.gie_din = 0; bus.clr_flags = 0;
    bus.pc_cur = 0; bus.call_tgt = 0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Basic CALL and its settle cycle
    step(1, 0, 0, 0, 0, 0, 0, 11'h010, 11'h200);
    check_eq("call_din", 32'(bus.stk_din), 32'h011);
    check_eq("call_next", 32'(bus.pc_next), 32'h200);
    check_eq("call_depth", 32'(bus.depth), 1);
    step(1, 0, 0, 0, 0, 0, 0, 11'h020, 11'h300);  // ignored during settle
    idle();

    // Fill past capacity, then drain past empty
    reset_now("rst_a");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 11'h100 + 11'(i), 11'h400);
      check_eq("fill_depth", 32'(bus.depth), (i < 4) ? i + 1 : 4);
      idle();
    end
    check_eq("fill_ovf", 32'(bus.ovf), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0, 0, 11'h000, 11'h000);
      if (i < 4) check_eq("drain_pc", 32'(bus.pc_next), 32'(11'h105 - 11'(i)));
      idle();
    end
    check_eq("drain_unf", 32'(bus.unf), 1);
    check_eq("drain_depth", 32'(bus.depth), 0);

    // CALL at top of address space wraps
    step(1, 0, 0, 0, 0, 0, 1, 11'h7FF, 11'h001);
    check_eq("wrap_din", 32'(bus.stk_din), 32'h000);
    idle();

    // Interrupt beats a coincident CALL
    step(0, 0, 0, 0, 1, 1, 0, 11'h000, 11'h000);
    step(1, 0, 0, 1, 0, 0, 0, 11'h055, 11'h222);
    check_eq("int_din", 32'(bus.stk_din), 32'h055);
    check_eq("int_next", 32'(bus.pc_next), 32'(IntVec));
    check_eq("int_ack", 32'(bus.int_ack), 1);
    check_eq("int_gie", 32'(bus.gie), 0);
    idle();

    // RETFIE with int_req held: accepted right after settle
    step(0, 0, 1, 1, 0, 0, 0, 11'h004, 11'h000);
    check_eq("retfie_next", 32'(bus.pc_next), 32'h055);
    check_eq("retfie_gie", 32'(bus.gie), 1);
    step(0, 0, 0, 1, 0, 0, 0, 11'h056, 11'h000);
    step(0, 0, 0, 1, 0, 0, 0, 11'h056, 11'h000);
    check_eq("reint_ack", 32'(bus.int_ack), 1);
    idle();

    // clr_flags against an overflowing push: set wins
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0, 1, 11'h300 + 11'(i), 11'h500);
      idle();
    end
    step(1, 0, 0, 0, 0, 0, 1, 11'h3AA, 11'h500);
    check_eq("clr_vs_ovf", 32'(bus.ovf), 1);

    // Reset while in SETTLE
    reset_now("rst_settle");
    idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [10:0] pc;
      pc = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 15) == 0) pc = 11'h7FF;
      if (m_busy && $urandom_range(0, 99) == 0) begin
        reset_now("rst_rand");
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 19) == 0, pc, 11'($urandom_range(0, 2047)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
